// File: rtl/aes_dec_scheduler_pkg.sv
// Shared types and defaults for the AES decrypt-engine scheduler.
package aes_dec_scheduler_pkg;
    localparam int AES_BLK_W   = 128;
    localparam int NR_DEF      = 10;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/aes_dec_scheduler_if.sv
// Request, core and response signals of the scheduler; master = scheduler side.
interface aes_dec_scheduler_if;
    import aes_dec_scheduler_pkg::*;

    logic                 req0_valid;
    logic [AES_BLK_W-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [AES_BLK_W-1:0] req1_data;
    logic                 req1_ready;
    logic                 core_start;
    logic [AES_BLK_W-1:0] core_din;
    logic                 core_abort;
    logic                 core_done;
    logic [AES_BLK_W-1:0] core_dout;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [AES_BLK_W-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  core_done, core_dout, rsp_ready,
        output req0_ready, req1_ready, core_start, core_din, core_abort,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        output core_done, core_dout, rsp_ready,
        input  req0_ready, req1_ready, core_start, core_din, core_abort,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/aes_dec_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when the grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       any,
    output logic       gnt_id
);
    logic ptr;

    assign any    = |valid;
    assign gnt_id = valid[ptr] ? ptr : ~ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~gnt_id;
        end
    end
endmodule

// File: rtl/aes_dec_scheduler.sv
// Shares one iterative AES inverse-cipher core between two requesters,
// with a watchdog on core completion and a tagged valid/ready response.
module aes_dec_scheduler
    import aes_dec_scheduler_pkg::*;
#(
    parameter int NR      = NR_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic                 clk,
    input logic                 rst,
    aes_dec_scheduler_if.master bus
);
    if (TIMEOUT <= 4 * NR) begin : g_bad_timeout
        $error("TIMEOUT must exceed the nominal core latency 4*NR");
    end
    if ((1 << CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cap_id;
    logic             req_any;
    logic             gnt_id;
    logic             accept;

    // Ready is combinational so the requester sees acceptance in the grant cycle.
    assign accept         = (state == IDLE) && req_any && !rst;
    assign bus.req0_ready = accept && !gnt_id;
    assign bus.req1_ready = accept && gnt_id;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .accept (accept),
        .any    (req_any),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_id         <= 1'b0;
            bus.core_start <= 1'b0;
            bus.core_din   <= '0;
            bus.core_abort <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            bus.core_start <= 1'b0;
            bus.core_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        bus.core_din   <= gnt_id ? bus.req1_data : bus.req0_data;
                        cap_id         <= gnt_id;
                        bus.core_start <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the timeout cycle still counts as success.
                    if (bus.core_done) begin
                        bus.rsp_data  <= bus.core_dout;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_id    <= cap_id;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.core_abort <= 1'b1;
                        bus.rsp_data   <= '0;
                        bus.rsp_err    <= 1'b1;
                        bus.rsp_id     <= cap_id;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
